// File: rtl/spi_pkg.sv
// Shared SPI link definitions: frame width, SCLK idle level and the serf state type.
package spi_pkg;

  localparam int   SPI_WIDTH = 16;
  localparam logic SCLK_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2
  } serf_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser with an edge-history flop; emits the synced level
// plus one-clk rise/fall pulses.
module spi_sync_edge #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [DEPTH-1:0] r_sync;
  logic             r_hist;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the previous stage's value from before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {DEPTH{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[DEPTH-2:0], i_async};
      r_hist <= r_sync[DEPTH-1];
    end
  end

  assign o_level = r_sync[DEPTH-1];
  assign o_rise  = o_level & ~r_hist;
  assign o_fall  = ~o_level & r_hist;

endmodule

// File: rtl/spi_serf.sv
// SPI serf (responder) for the 16-bit link: samples MOSI on SCLK rise, advances MISO on fall.
// Optional early-command support is enabled with `define SPI_SERF_CMD_EARLY_EN.
module spi_serf
  import spi_pkg::*;
#(
  parameter int WIDTH    = SPI_WIDTH,
  parameter int SYNC_STG = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               SCLK,
  input  logic               MOSI,
  output logic               MISO,
  input  logic [WIDTH-1:0]   tx_data,
  output logic [WIDTH-1:0]   rx_data,
  output logic               rx_rdy,
  output logic               frm_err,
  output logic               busy,
  output logic               cmd_vld,
  output logic [WIDTH/2-1:0] cmd,
  input  logic [WIDTH/2-1:0] resp_byte
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(2 * WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);

  serf_state_t      r_state;
  logic [WIDTH-1:0] r_tx_sr;
  logic [WIDTH-1:0] r_rx_sr;
  logic [CW-1:0]    r_rise_cnt;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_rdy;
  logic             r_frm_err;

  logic w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall, w_mosi;
  logic w_ss_lvl, w_sclk_lvl;
  logic [1:0] w_unused_mosi_edges;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_rx_nxt;
  logic [WIDTH-1:0] w_tx_fall;
  logic             w_load_resp;

  spi_sync_edge #(.DEPTH(SYNC_STG), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .i_async(SS_n),
    .o_level(w_ss_lvl), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  spi_sync_edge #(.DEPTH(SYNC_STG), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_async(SCLK),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  // Same depth as SCLK so a detected rise sees MOSI from the same sample instant.
  spi_sync_edge #(.DEPTH(SYNC_STG), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .i_async(MOSI),
    .o_level(w_mosi), .o_rise(w_unused_mosi_edges[0]), .o_fall(w_unused_mosi_edges[1])
  );

  assign w_cnt_nxt = (w_sclk_rise && (r_rise_cnt != CNT_MAX)) ? r_rise_cnt + CW'(1) : r_rise_cnt;
  assign w_rx_nxt  = w_sclk_rise ? {r_rx_sr[WIDTH-2:0], w_mosi} : r_rx_sr;
  assign w_tx_fall = w_load_resp ? {resp_byte, {HALF{1'b0}}} : {r_tx_sr[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_rise_cnt <= '0;
      r_rx_data  <= '0;
      r_rx_rdy   <= 1'b0;
      r_frm_err  <= 1'b0;
    end else begin
      r_rx_rdy  <= 1'b0;
      r_frm_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ss_fall) begin
            r_tx_sr    <= tx_data;
            r_rise_cnt <= '0;
            r_state    <= ARMED;
          end
        end
        ARMED, SHIFT: begin
          if (w_ss_rise) begin
            // A rise in the closing clk is already folded into w_cnt_nxt/w_rx_nxt.
            r_state <= IDLE;
            if (w_cnt_nxt == CNT_FULL) begin
              r_rx_data <= w_rx_nxt;
              r_rx_rdy  <= 1'b1;
            end else begin
              r_frm_err <= 1'b1;
            end
          end else begin
            r_rx_sr    <= w_rx_nxt;
            r_rise_cnt <= w_cnt_nxt;
            if (w_sclk_rise) r_state <= SHIFT;
            // The leading fall arrives while ARMED and must not shift.
            if (w_sclk_fall && (r_state == SHIFT)) r_tx_sr <= w_tx_fall;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SERF_CMD_EARLY_EN
  logic            r_cmd_vld;
  logic [HALF-1:0] r_cmd;
  logic            r_resp_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_vld   <= 1'b0;
      r_cmd       <= '0;
      r_resp_pend <= 1'b0;
    end else begin
      r_cmd_vld <= 1'b0;
      if (r_state == IDLE) begin
        r_resp_pend <= 1'b0;
      end else if (!w_ss_rise && w_sclk_rise && (w_cnt_nxt == CNT_HALF)) begin
        r_cmd       <= w_rx_nxt[HALF-1:0];
        r_cmd_vld   <= 1'b1;
        r_resp_pend <= 1'b1;
      end else if (w_sclk_fall && (r_state == SHIFT)) begin
        r_resp_pend <= 1'b0;
      end
    end
  end

  assign cmd_vld     = r_cmd_vld;
  assign cmd         = r_cmd;
  assign w_load_resp = r_resp_pend;
`else
  assign cmd_vld     = 1'b0;
  assign cmd         = '0;
  assign w_load_resp = 1'b0;
`endif

  assign MISO    = (r_state != IDLE) & r_tx_sr[WIDTH-1];
  assign busy    = (r_state != IDLE);
  assign rx_data = r_rx_data;
  assign rx_rdy  = r_rx_rdy;
  assign frm_err = r_frm_err;

endmodule
